// File: rtl/reg_file_mp_amisha_pkg.sv
// Shared types and default geometry for the dual-read register file.
// Optional write-through bypass is selected with RF_WR_BYPASS_EN (see top).
package reg_file_pkg_amisha;

   localparam int unsigned RF_B_DEF = 8;
   localparam int unsigned RF_W_DEF = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } rf_state_e;

endpackage

// File: rtl/reg_file_mp_amisha_if.sv
// Bus bundle for the dual-read register file: one write port, two read ports,
// clear request and status flags.
interface reg_file_mp_amisha_if
   import reg_file_pkg_amisha::*;
#(
   parameter int unsigned B_amisha = RF_B_DEF,
   parameter int unsigned W_amisha = RF_W_DEF
);

   logic                wr_en_amisha;
   logic [W_amisha-1:0] w_addr_amisha;
   logic [B_amisha-1:0] w_data_amisha;
   logic [W_amisha-1:0] r_addr_a_amisha;
   logic [W_amisha-1:0] r_addr_b_amisha;
   logic [B_amisha-1:0] r_data_a_amisha;
   logic [B_amisha-1:0] r_data_b_amisha;
   logic                clr_req_amisha;
   logic                busy_amisha;
   logic                wr_drop_amisha;

   modport master (
      output wr_en_amisha, w_addr_amisha, w_data_amisha,
      output r_addr_a_amisha, r_addr_b_amisha, clr_req_amisha,
      input  r_data_a_amisha, r_data_b_amisha, busy_amisha, wr_drop_amisha
   );

   modport slave (
      input  wr_en_amisha, w_addr_amisha, w_data_amisha,
      input  r_addr_a_amisha, r_addr_b_amisha, clr_req_amisha,
      output r_data_a_amisha, r_data_b_amisha, busy_amisha, wr_drop_amisha
   );

endinterface

// File: rtl/reg_file_mp_amisha_clr_seq.sv
// Clear sequencer: walks every entry once after reset or on request,
// driving a clear strobe and address and flagging busy meanwhile.
module rf_clr_seq_amisha
   import reg_file_pkg_amisha::*;
#(
   parameter int unsigned W_amisha = RF_W_DEF
) (
   input  logic                clk_amisha,
   input  logic                reset_amisha,
   input  logic                clr_req_amisha,
   output logic                busy_amisha,
   output logic                clr_en_amisha,
   output logic [W_amisha-1:0] clr_addr_amisha
);

   rf_state_e           state_q, state_d;
   logic [W_amisha-1:0] clr_ptr_q, clr_ptr_d;

   always_ff @(posedge clk_amisha) begin
      if (reset_amisha) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      clr_ptr_d     = clr_ptr_q;
      clr_en_amisha = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_req_amisha) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         ST_CLEAR: begin
            clr_en_amisha = 1'b1;
            clr_ptr_d     = clr_ptr_q + 1'b1;
            // Depth is a power of two, so the last entry is all-ones and the pointer wraps to 0.
            if (&clr_ptr_q) state_d = ST_IDLE;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign busy_amisha     = (state_q == ST_CLEAR);
   assign clr_addr_amisha = clr_ptr_q;

endmodule

// File: rtl/reg_file_mp_amisha.sv
// Dual-read, single-write register file with hardware clear and dropped-write flag.
// Define RF_WR_BYPASS_EN for same-cycle write-through on matching read addresses.
module reg_file_mp_amisha
   import reg_file_pkg_amisha::*;
#(
   parameter int unsigned B_amisha = RF_B_DEF,
   parameter int unsigned W_amisha = RF_W_DEF
) (
   input  logic                 clk_amisha,
   input  logic                 reset_amisha,
   reg_file_mp_amisha_if.slave  bus_amisha
);

   localparam int unsigned N_amisha = 2 ** W_amisha;

   logic [B_amisha-1:0] mem_q [N_amisha];
   logic                busy;
   logic                clr_en;
   logic [W_amisha-1:0] clr_addr;
   logic                wr_ok;
   logic                wr_drop_q, wr_drop_d;
   logic [B_amisha-1:0] rd_a, rd_b;

   rf_clr_seq_amisha #(
      .W_amisha (W_amisha)
   ) u_clr_seq (
      .clk_amisha      (clk_amisha),
      .reset_amisha    (reset_amisha),
      .clr_req_amisha  (bus_amisha.clr_req_amisha),
      .busy_amisha     (busy),
      .clr_en_amisha   (clr_en),
      .clr_addr_amisha (clr_addr)
   );

   // A clear request takes the edge, so a coincident write is rejected.
   assign wr_ok     = !busy && bus_amisha.wr_en_amisha && !bus_amisha.clr_req_amisha;
   assign wr_drop_d = bus_amisha.wr_en_amisha && (busy || bus_amisha.clr_req_amisha);

   // Array has no reset; contents are always swept by the clear that reset triggers.
   always_ff @(posedge clk_amisha) begin
      if (!reset_amisha) begin
         if (clr_en) begin
            mem_q[clr_addr] <= '0;
         end else if (wr_ok) begin
            mem_q[bus_amisha.w_addr_amisha] <= bus_amisha.w_data_amisha;
         end
      end
   end

   always_ff @(posedge clk_amisha) begin
      if (reset_amisha) wr_drop_q <= 1'b0;
      else              wr_drop_q <= wr_drop_d;
   end

   always_comb begin
      rd_a = mem_q[bus_amisha.r_addr_a_amisha];
      rd_b = mem_q[bus_amisha.r_addr_b_amisha];
`ifdef RF_WR_BYPASS_EN
      if (!busy && bus_amisha.wr_en_amisha) begin
         if (bus_amisha.r_addr_a_amisha == bus_amisha.w_addr_amisha) rd_a = bus_amisha.w_data_amisha;
         if (bus_amisha.r_addr_b_amisha == bus_amisha.w_addr_amisha) rd_b = bus_amisha.w_data_amisha;
      end
`else
      // Read-during-write returns the old entry; the new value shows next cycle.
`endif
      // Stale pre-clear contents must never leak out while sweeping.
      if (busy) begin
         rd_a = '0;
         rd_b = '0;
      end
   end

   assign bus_amisha.r_data_a_amisha = rd_a;
   assign bus_amisha.r_data_b_amisha = rd_b;
   assign bus_amisha.busy_amisha     = busy;
   assign bus_amisha.wr_drop_amisha  = wr_drop_q;

endmodule

// File: tb/tb_reg_file_mp_amisha.sv
// Directed self-checking bench for reg_file_mp_amisha using an expectation queue.
module tb_reg_file_mp_amisha;

   logic clk_amisha = 1'b0;
   logic reset_amisha;

   always #5 clk_amisha = ~clk_amisha;

   reg_file_mp_amisha_if #(.B_amisha(8), .W_amisha(2)) rf_if ();

   reg_file_mp_amisha #(
      .B_amisha (8),
      .W_amisha (2)
   ) dut (
      .clk_amisha   (clk_amisha),
      .reset_amisha (reset_amisha),
      .bus_amisha   (rf_if.slave)
   );

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic push(input string tag, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [7:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL sb_empty: observed %h with no expected value queued", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_amisha);
      #1;
   endtask

   task automatic chk_busy(input string tag, input logic exp);
      push(tag, {7'd0, exp});
      #1;
      pop_chk({7'd0, rf_if.busy_amisha});
   endtask

   task automatic chk_drop(input string tag, input logic exp);
      push(tag, {7'd0, exp});
      #1;
      pop_chk({7'd0, rf_if.wr_drop_amisha});
   endtask

   task automatic chk_read(input string tag, input logic [1:0] aa, input logic [7:0] ea,
                           input logic [1:0] ab, input logic [7:0] eb);
      rf_if.r_addr_a_amisha = aa;
      rf_if.r_addr_b_amisha = ab;
      push({tag, "_a"}, ea);
      push({tag, "_b"}, eb);
      #1;
      pop_chk(rf_if.r_data_a_amisha);
      pop_chk(rf_if.r_data_b_amisha);
   endtask

   task automatic chk_all_zero(input string tag);
      for (int a = 0; a < 4; a++) chk_read(tag, 2'(a), 8'h00, 2'(3 - a), 8'h00);
   endtask

   initial begin
      reset_amisha          = 1'b1;
      rf_if.wr_en_amisha    = 1'b0;
      rf_if.w_addr_amisha   = '0;
      rf_if.w_data_amisha   = '0;
      rf_if.r_addr_a_amisha = '0;
      rf_if.r_addr_b_amisha = '0;
      rf_if.clr_req_amisha  = 1'b0;

      // Reset for two edges, then the 4-cycle clear.
      tick();
      tick();
      chk_drop("reset_drop", 1'b0);
      reset_amisha = 1'b0;
      chk_busy("rst_busy0", 1'b1);
      chk_read("busy_forced0", 2'd0, 8'h00, 2'd3, 8'h00);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk_busy("rst_busy", 1'b1);
      end
      tick();
      chk_busy("rst_idle", 1'b0);
      chk_all_zero("post_rst");

      // Plain write then dual read of the same address.
      rf_if.wr_en_amisha  = 1'b1;
      rf_if.w_addr_amisha = 2'd2;
      rf_if.w_data_amisha = 8'hA5;
      tick();
      rf_if.wr_en_amisha = 1'b0;
      chk_read("wr_a5", 2'd2, 8'hA5, 2'd2, 8'hA5);
      chk_drop("wr_a5_nodrop", 1'b0);
      chk_read("other01", 2'd0, 8'h00, 2'd1, 8'h00);
      chk_read("other3", 2'd3, 8'h00, 2'd2, 8'hA5);

      // Write while busy is dropped.
      rf_if.clr_req_amisha = 1'b1;
      tick();
      rf_if.clr_req_amisha = 1'b0;
      chk_busy("req_busy0", 1'b1);
      rf_if.wr_en_amisha  = 1'b1;
      rf_if.w_addr_amisha = 2'd1;
      rf_if.w_data_amisha = 8'h3C;
      tick();
      rf_if.wr_en_amisha = 1'b0;
      chk_drop("busy_drop", 1'b1);
      chk_busy("req_busy1", 1'b1);
      tick();
      chk_drop("busy_drop_end", 1'b0);
      chk_busy("req_busy2", 1'b1);
      tick();
      chk_busy("req_busy3", 1'b1);
      tick();
      chk_busy("req_idle", 1'b0);
      chk_read("dropped_addr1", 2'd1, 8'h00, 2'd2, 8'h00);

      // Fill, then clear request racing a write.
      for (int a = 0; a < 4; a++) begin
         rf_if.wr_en_amisha  = 1'b1;
         rf_if.w_addr_amisha = 2'(a);
         rf_if.w_data_amisha = 8'(8'h11 * (a + 1));
         tick();
      end
      rf_if.wr_en_amisha = 1'b0;
      chk_read("fill01", 2'd0, 8'h11, 2'd1, 8'h22);
      chk_read("fill23", 2'd2, 8'h33, 2'd3, 8'h44);
      rf_if.clr_req_amisha = 1'b1;
      rf_if.wr_en_amisha   = 1'b1;
      rf_if.w_addr_amisha  = 2'd0;
      rf_if.w_data_amisha  = 8'hFF;
      tick();
      rf_if.clr_req_amisha = 1'b0;
      rf_if.wr_en_amisha   = 1'b0;
      chk_drop("clr_prio_drop", 1'b1);
      chk_busy("clr2_busy0", 1'b1);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk_busy("clr2_busy", 1'b1);
      end
      tick();
      chk_busy("clr2_idle", 1'b0);
      chk_all_zero("post_clr2");

      // Reset at clr_ptr=2 restarts the full clear; clr_req inside it is ignored.
      rf_if.clr_req_amisha = 1'b1;
      tick();
      rf_if.clr_req_amisha = 1'b0;
      tick();
      tick();
      reset_amisha = 1'b1;
      tick();
      reset_amisha = 1'b0;
      chk_busy("rst_mid_busy0", 1'b1);
      for (int i = 1; i < 4; i++) begin
         tick();
         rf_if.clr_req_amisha = (i == 1);
         chk_busy("rst_mid_busy", 1'b1);
      end
      rf_if.clr_req_amisha = 1'b0;
      tick();
      chk_busy("rst_mid_idle", 1'b0);
      tick();
      chk_busy("no_extend", 1'b0);

      // Read-during-write on port A; port B on another address.
      rf_if.wr_en_amisha  = 1'b1;
      rf_if.w_addr_amisha = 2'd3;
      rf_if.w_data_amisha = 8'h77;
      tick();
      rf_if.w_data_amisha = 8'h5A;
`ifdef RF_WR_BYPASS_EN
      chk_read("rdw_same", 2'd3, 8'h5A, 2'd2, 8'h00);
`else
      chk_read("rdw_same", 2'd3, 8'h77, 2'd2, 8'h00);
`endif
      tick();
      rf_if.wr_en_amisha = 1'b0;
      chk_read("rdw_next", 2'd3, 8'h5A, 2'd2, 8'h00);

      n_cmp++;
      assert (sb.size() == 0) else begin
         n_err++;
         $error("FAIL sb_leftover: observed %0d queued expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
